// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: opcode-id field position, HALT encoding and fetch FSM states.
package fetch_defs;

  localparam int ID_MSB   = 31;
  localparam int ID_LSB   = 25;
  localparam int ID_WIDTH = ID_MSB - ID_LSB + 1;

  // Type 00 system op; stops the fetch stage once it reaches IF/ID.
  localparam logic [ID_WIDTH-1:0] HALT_ID = 7'b0011111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_id(input logic [ID_WIDTH-1:0] id);
    return (id == HALT_ID);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: hazard/branch control in, instruction memory port, IF/ID register out.
interface fetch_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32
);

  logic                            stall;
  logic                            redirect_valid;
  logic [ADDR_WIDTH-1:0]           redirect_pc;
  logic [ADDR_WIDTH-1:0]           imem_addr;
  logic                            imem_en;
  logic [INSTR_WIDTH-1:0]          imem_rdata;
  logic [INSTR_WIDTH-1:0]          instr;
  logic [fetch_defs::ID_WIDTH-1:0] instr_id;
  logic [ADDR_WIDTH-1:0]           instr_pc;
  logic                            instr_valid;
  logic                            halted;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, imem_en, instr, instr_id, instr_pc, instr_valid, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, imem_en, instr, instr_id, instr_pc, instr_valid, halted
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, synchronous imem request tracking, IF/ID register, RUN/HALT control.
module fetch_stage
  import fetch_defs::*;
#(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
  parameter int                    PC_STEP     = 4
) (
  input logic            clk,
  input logic            rst_n,
  fetch_stage_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  fetch_state_t           state_r, state_nxt;
  logic [ADDR_WIDTH-1:0]  fetch_pc_r, fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0]  req_pc_r, req_pc_nxt;
  logic                   req_valid_r, req_valid_nxt;
  logic [INSTR_WIDTH-1:0] instr_r, instr_nxt;
  logic [ADDR_WIDTH-1:0]  instr_pc_r, instr_pc_nxt;
  logic                   instr_valid_r, instr_valid_nxt;
  logic                   redirect_s;

  assign redirect_s = bus.redirect_valid && (state_r == RUN);

  // On stall the previous address is replayed so next-cycle data still belongs to req_pc.
  always_comb begin
    if (redirect_s) begin
      bus.imem_addr = bus.redirect_pc;
    end else if (bus.stall) begin
      bus.imem_addr = req_pc_r;
    end else begin
      bus.imem_addr = fetch_pc_r;
    end
  end

  // Next-state and register-update selection for the RUN/HALT controller.
  always_comb begin
    state_nxt       = state_r;
    fetch_pc_nxt    = fetch_pc_r;
    req_pc_nxt      = req_pc_r;
    req_valid_nxt   = req_valid_r;
    instr_nxt       = instr_r;
    instr_pc_nxt    = instr_pc_r;
    instr_valid_nxt = instr_valid_r;
    case (state_r)
      RUN: begin
        if (bus.redirect_valid) begin
          fetch_pc_nxt    = bus.redirect_pc + STEP;
          req_pc_nxt      = bus.redirect_pc;
          req_valid_nxt   = 1'b1;
          instr_nxt       = {INSTR_WIDTH{1'b0}};
          instr_valid_nxt = 1'b0;
        end else if (bus.stall) begin
          state_nxt = RUN;
        end else begin
          instr_nxt       = bus.imem_rdata;
          instr_pc_nxt    = req_pc_r;
          instr_valid_nxt = req_valid_r;
          req_pc_nxt      = fetch_pc_r;
          fetch_pc_nxt    = fetch_pc_r + STEP;
          if (req_valid_r && is_halt_id(bus.imem_rdata[INSTR_WIDTH-1 -: ID_WIDTH])) begin
            state_nxt     = HALT;
            req_valid_nxt = 1'b0;
          end else begin
            req_valid_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        if (!bus.stall) begin
          instr_nxt       = {INSTR_WIDTH{1'b0}};
          instr_valid_nxt = 1'b0;
        end else begin
          instr_valid_nxt = instr_valid_r;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      fetch_pc_r    <= RESET_PC;
      req_pc_r      <= {ADDR_WIDTH{1'b0}};
      req_valid_r   <= 1'b0;
      instr_r       <= {INSTR_WIDTH{1'b0}};
      instr_pc_r    <= {ADDR_WIDTH{1'b0}};
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      fetch_pc_r    <= fetch_pc_nxt;
      req_pc_r      <= req_pc_nxt;
      req_valid_r   <= req_valid_nxt;
      instr_r       <= instr_nxt;
      instr_pc_r    <= instr_pc_nxt;
      instr_valid_r <= instr_valid_nxt;
    end
  end

  assign bus.imem_en     = (state_r == RUN);
  assign bus.halted      = (state_r == HALT);
  assign bus.instr       = instr_r;
  assign bus.instr_id    = instr_r[INSTR_WIDTH-1 -: ID_WIDTH];
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts each cycle's outputs.
module tb_fetch_stage;
  import fetch_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  fetch_stage #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Memory image: word at address a encodes a/4; a single configurable address may hold HALT.
  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h10;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return {HALT_ID, a[26:2]};
    return {7'b0010000, a[26:2]};
  endfunction

  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= word(bus.imem_addr);

  // Reference model: next sequential address, one outstanding read, the IF/ID contents.
  logic [31:0] m_fetch, m_req, m_instr, m_pc;
  bit          m_req_v, m_valid, m_known, m_halted;

  typedef struct {
    logic [31:0] addr;
    bit          en;
    logic [31:0] instr;
    bit          chk_instr;
    logic [31:0] pc;
    bit          valid;
    bit          halted;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 32'h0; m_req = 32'h0; m_req_v = 1'b0;
    m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_known = 1'b1; m_halted = 1'b0;
  endtask

  task automatic model_edge(input bit rn, input bit s, input bit r, input logic [31:0] rpc);
    logic [31:0] w;
    if (!rn) begin
      model_reset();
    end else if (m_halted) begin
      if (!s) begin m_valid = 1'b0; m_instr = 32'h0; m_known = 1'b1; end
    end else if (r) begin
      m_valid = 1'b0; m_instr = 32'h0; m_known = 1'b1;
      m_req = rpc; m_req_v = 1'b1; m_fetch = rpc + 32'd4;
    end else if (!s) begin
      w = word(m_req);
      m_valid = m_req_v; m_pc = m_req; m_instr = w; m_known = m_req_v;
      if (m_req_v && w[31:25] == HALT_ID) begin
        m_halted = 1'b1; m_req_v = 1'b0;
      end else begin
        m_req_v = 1'b1;
      end
      m_req = m_fetch;
      m_fetch = m_fetch + 32'd4;
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic cyc(input bit rn, input bit s, input bit r, input logic [31:0] rpc);
    exp_t e;
    rst_n = rn;
    if (!rn) model_reset();
    bus.stall = s; bus.redirect_valid = r; bus.redirect_pc = rpc;
    e.en = !m_halted;
    e.addr = (!m_halted && r) ? rpc : (s ? m_req : m_fetch);
    e.instr = m_instr; e.chk_instr = m_known;
    e.pc = m_pc; e.valid = m_valid; e.halted = m_halted;
    q.push_back(e);
    @(posedge clk); #1;
    model_edge(rn, s, r, rpc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // kind 0: IF/ID shows valid pc a; kind 1: halted; kind 2: read of a outstanding in RUN.
  task automatic wait_model(input int kind, input logic [31:0] a);
    int n = 0;
    bit hit;
    forever begin
      case (kind)
        0:       hit = m_valid && m_pc == a;
        1:       hit = m_halted;
        default: hit = m_req_v && m_req == a && !m_halted;
      endcase
      if (hit) break;
      if (n >= 40) begin
        checks++; errors++;
        $display("FAIL wait_model kind %0d addr %h: condition not reached in 40 cycles", kind, a);
        break;
      end
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
  endtask

  // Monitor: every cycle pop the prediction and compare all observable outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("halted", {31'h0, bus.halted}, {31'h0, e.halted});
        check("imem_en", {31'h0, bus.imem_en}, {31'h0, e.en});
        if (e.en) check("imem_addr", bus.imem_addr, e.addr);
        check("instr_valid", {31'h0, bus.instr_valid}, {31'h0, e.valid});
        if (e.valid) check("instr_pc", bus.instr_pc, e.pc);
        if (e.chk_instr) begin
          check("instr", bus.instr, e.instr);
          check("instr_id", {25'h0, bus.instr_id}, {25'h0, e.instr[31:25]});
        end
      end
    end
  end

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    model_reset();
    @(posedge clk); #1;

    // Reset and straight-line fetch
    do_reset(3);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Stall for three cycles while IF/ID holds pc 8
    do_reset(2);
    wait_model(0, 32'h8);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect, then redirect together with stall
    do_reset(2);
    wait_model(0, 32'h4);
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset(2);
    wait_model(0, 32'h4);
    cyc(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect to the top of the address space wraps silently
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // HALT at 0x10: held under stall, then bubble, redirect ignored
    halt_en = 1'b1; halt_addr = 32'h10;
    do_reset(2);
    wait_model(1, 32'h0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // HALT squashed by a same-cycle redirect, then asynchronous reset mid-stream
    do_reset(2);
    wait_model(2, 32'h10);
    cyc(1'b1, 1'b0, 1'b1, 32'h80);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset(1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Random control without HALT in memory
    halt_en = 1'b0;
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rpc);
    end

    // Random control with HALT reachable and occasional resets
    halt_en = 1'b1; halt_addr = 32'h20;
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rpc;
      bit rn;
      rpc = {26'h0, $urandom_range(0, 15) == 0 ? 6'h20 : 6'($urandom_range(0, 15) * 4)};
      rn = ($urandom_range(0, 39) != 0);
      cyc(rn, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rpc);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the vector CPU pipeline: owns the program counter, drives the synchronous instruction memory, and holds the IF/ID pipeline register. Its 7-bit `instr_id` output feeds the `Id` input of `control_unit` directly. It supports stall from hazard logic, redirect from branch resolution in execute, and stops fetching after a HALT system instruction.

## Interface
- `INSTR_WIDTH`, 32: instruction word width; `instr_id` = bits [INSTR_WIDTH-1 -: 7].
- `ADDR_WIDTH`, 32: byte address width of PC and memory port.
- `RESET_PC`, 0: first fetch address after reset.
- `PC_STEP`, 4: PC increment per instruction.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the IF/ID register and PC.
- `redirect_valid` in 1: taken branch or jump resolved in execute.
- `redirect_pc` in ADDR_WIDTH: target address.
- `imem_addr` out ADDR_WIDTH: fetch address, combinational.
- `imem_en` out 1: read enable.
- `imem_rdata` in INSTR_WIDTH: data for the address presented in the previous cycle.
- `instr` out INSTR_WIDTH: IF/ID instruction.
- `instr_id` out 7: `instr[31:25]`, goes to `control_unit.Id`.
- `instr_pc` out ADDR_WIDTH: address of `instr`.
- `instr_valid` out 1: `instr` is a real instruction. A bubble reads as 0 (system op, no writes).
- `halted` out 1: HALT has been captured and fetch has stopped.

## Operation
- **Registers:** `fetch_pc`, `req_pc`, `req_valid`, IF/ID (`instr`, `instr_pc`, `instr_valid`), and a 2-state FSM `RUN` / `HALT`.
- **Reset values:** `fetch_pc`=RESET_PC, `req_pc`=0, `req_valid`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, state RUN. Outputs follow: `halted`=0, `imem_en`=1, `imem_addr`=RESET_PC.
- **`imem_addr` priority:**
  1. `redirect_valid` (and state RUN): `redirect_pc`.
  2. Else `stall`: `req_pc` (replay, so next-cycle data still matches `req_pc`).
  3. Else `fetch_pc`.
- **`imem_en`:** 1 in RUN, 0 in HALT.
- **RUN, redirect (highest priority, overrides stall):**
  - `fetch_pc` <= `redirect_pc`+PC_STEP; `req_pc` <= `redirect_pc`; `req_valid` <= 1.
  - `instr_valid` <= 0 and `instr` <= 0 (flush wrong-path instruction).
- **RUN, stall, no redirect:** all registers hold.
- **RUN, advance:**
  - IF/ID <= {`imem_rdata`, `req_pc`, `req_valid`}.
  - `req_pc` <= `fetch_pc`; `req_valid` <= 1; `fetch_pc` <= `fetch_pc`+PC_STEP.
- **HALT detection:** during an advance where `req_valid`=1 and `imem_rdata[31:25]`==HALT_ID:
  - The HALT word is still captured into IF/ID with valid=1.
  - State -> HALT; `req_valid` <= 0.
- **HALT state:**
  - The HALT instruction stays in IF/ID while `stall`=1. On the first non-stalled cycle, IF/ID <= bubble (0, valid 0).
  - `redirect_valid` is ignored; PC registers hold.
  - `halted`=1 for as long as state is HALT. Only `rst_n` leaves HALT.
- **Arithmetic:** PC addition is modulo 2^ADDR_WIDTH; wrap from the max address to 0 is silent. No alignment check; low bits pass through.
- **Simultaneous events:** redirect in the same cycle as HALT detection means the HALT is on the wrong path; redirect wins and state stays RUN.
- **Reset mid-operation:** asynchronous clear to the reset values above. Any in-flight memory data is discarded because `req_valid`=0.

## Timing
- **Fetch latency:** address issued in cycle N, data arrives in N+1, IF/ID valid after the edge ending N+1. The first valid `instr` appears 2 cycles after reset deassertion.
- **Throughput:** one instruction per cycle without stall or redirect.
- **Redirect penalty:** exactly one bubble. The target is in IF/ID 2 edges after the redirect cycle.
- **Stall:** zero-latency hold; release resumes the next cycle with no lost or duplicated instruction.
- **`halted`:** rises on the same edge that captures HALT into IF/ID.

## Structure
- **Package `fetch_defs`:** `HALT_ID` = 7'b0011111 (type 00 system op), `fetch_state_t` enum {RUN, HALT}, `ID_MSB`/`ID_LSB` field constants shared with the decode path.
- **Sub-modules:** none required. The PC adder and muxes stay inline; the optional sub-module `pc_reg` is not warranted.

## Test plan
- **Reset, straight-line fetch:** RESET_PC=0, memory word k = 0x2000_0000+k, no stall → `instr_pc` 0,4,8,… on consecutive cycles, `instr_valid` rises 2 cycles after reset.
- **Stall:** stall held 3 cycles while `instr_pc`=8 → `instr_pc` stays 8 with the same `instr`, `imem_addr`=12 during stall, then 12,16 follow with no skip or duplicate.
- **Redirect:** `redirect_valid` with `redirect_pc`=0x40 while `instr_pc`=4 → next cycle `instr_valid`=0, following cycle `instr_pc`=0x40, then 0x44.
- **Redirect plus stall:** both asserted together → redirect taken, same response as the redirect scenario.
- **HALT:** word at 0x10 has [31:25]=0011111 → `instr_pc`=0x10 valid, `halted`=1 on the same edge, `imem_en`=0, then a bubble. A later redirect to 0x0 is ignored.
- **HALT squashed, then reset:** redirect in the same cycle HALT is fetched → `halted` stays 0. Then pulse `rst_n` low mid-stream → all outputs return to reset values immediately, fetch restarts at RESET_PC.
